// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide unit.
// One start pulse launches a 32-iteration operation on operand magnitudes.
// The sign and the special cases are applied when the result is written.
// Multiply uses radix-2 shift-add, LSB first. Divide uses restoring
// shift-subtract, MSB first. Both share one 64-bit working register.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_mult;
  logic        neg;       // result sign: signA ^ signB
  logic        div_zero;
  logic        div_ovf;   // 0x80000000 / -1
  logic [31:0] addend;    // multiplicand |A| or divisor |B|
  logic [63:0] acc;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}

  logic        start;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [31:0] shifted;
  logic [32:0] diff;
  logic [63:0] step_next;
  logic [63:0] prod_signed;
  logic [31:0] quot_signed;
  logic [31:0] fin_res;
  logic        fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;
  // The magnitude of 0x80000000 is 2^31, which still fits as an unsigned 32-bit value.
  assign mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // One iteration of either algorithm, plus the signed final result taken from that step.
  always_comb begin
    mul_sum     = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? addend : 32'd0)};
    // Remainder stays below the divisor (at most 2^31), so bit 62 down holds the shifted value.
    shifted     = acc[62:31];
    diff        = {1'b0, shifted} - {1'b0, addend};
    if (is_mult)
      step_next = {mul_sum, acc[31:1]};
    else if (diff[32])
      step_next = {shifted, acc[30:0], 1'b0};
    else
      step_next = {diff[31:0], acc[30:0], 1'b1};

    prod_signed = neg ? (64'd0 - step_next) : step_next;
    quot_signed = neg ? (32'd0 - step_next[31:0]) : step_next[31:0];

    if (is_mult) begin
      fin_res = prod_signed[31:0];
      fin_exc = ~((&prod_signed[63:31]) | ~(|prod_signed[63:31]));
    end else if (div_zero) begin
      fin_res = 32'd0;
      fin_exc = 1'b1;
    end else begin
      fin_res = quot_signed;
      fin_exc = div_ovf;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 5'd0;
      is_mult        <= 1'b0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      addend         <= 32'd0;
      acc            <= 64'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc <= step_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= fin_res;
            data_exception <= fin_exc;
          end
        end
        default: begin
          data_resultRDY <= 1'b0;
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            cnt      <= 5'd0;
            is_mult  <= ctrl_MULT;
            neg      <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            addend   <= ctrl_MULT ? mag_a : mag_b;
            acc      <= {32'd0, (ctrl_MULT ? mag_b : mag_a)};
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: cycle-level behavioural model checked every cycle,
// plus directed operations with hand-computed results and latency.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  multdiv_unit dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference straight from the signed math rules.
  function automatic void calc(input bit mult, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output bit e);
    longint p;
    logic [32:0] top;
    if (mult) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      r   = p[31:0];
      top = p[63:31];
      e   = !(top == 33'd0 || top == {33{1'b1}});
    end else if (b == 32'd0) begin
      r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0]; e = 1'b0;
    end
  endfunction

  // Model: a start while not busy launches a 32-cycle countdown; the result appears when it expires.
  bit          m_busy, m_rdy, m_exc, p_exc;
  logic [31:0] m_res, p_res;
  int          m_left;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_rdy = 0; m_exc = 0; m_res = 32'd0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_rdy = 1; m_res = p_res; m_exc = p_exc;
      end
    end else begin
      m_rdy = 0;
      if (ctrl_MULT || ctrl_DIV) begin
        m_busy = 1; m_left = 32;
        calc(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc busy", busy, m_busy);
      check("cyc rdy", data_resultRDY, m_rdy);
      check("cyc result", data_result, m_res);
      check("cyc exc", data_exception, m_exc);
    end
  end

  // All tasks are entered and left at a falling edge.
  task automatic start_op(input bit mult, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = mult; ctrl_DIV = !mult; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 1;
    while (!data_resultRDY && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input bit mult, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit ee);
    int c;
    start_op(mult, a, b);
    wait_rdy(c);
    check({name, " latency"}, c, 33);
    check({name, " result"}, data_result, er);
    check({name, " exc"}, data_exception, ee);
    @(negedge clock);
  endtask

  initial begin
    int c, pulses;
    logic [31:0] seen;
    #1 reset = 1;
    @(negedge clock);
    check("reset result", data_result, 32'd0);
    check("reset exc", data_exception, 0);
    check("reset rdy", data_resultRDY, 0);
    check("reset busy", busy, 0);
    chk_en = 1;
    @(negedge clock);
    reset = 0;
    @(negedge clock);

    run_op("mul 7x6", 1, 32'd7, 32'd6, 32'd42, 0);
    run_op("mul 2^16 sq", 1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1);
    run_op("mul -1x5", 1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 0);
    run_op("mul min x1", 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 0);
    run_op("div -7/2", 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("div 5/0", 0, 32'd5, 32'd0, 32'd0, 1);
    run_op("div min/-1", 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("div min/2", 0, 32'h8000_0000, 32'd2, 32'hC000_0000, 0);

    // A divide start in the middle of a multiply is ignored.
    start_op(1, 32'h0000_1234, 32'hFFFF_FFFD);
    repeat (9) @(negedge clock);
    ctrl_DIV = 1; data_operandA = 32'd100; data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 0;
    pulses = 0; seen = 32'd0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY) begin pulses++; seen = data_result; end
      @(negedge clock);
    end
    check("ignored div pulses", pulses, 1);
    check("ignored div result", seen, 32'hFFFF_C964);

    // Back-to-back: a new start in the DONE cycle.
    start_op(0, 32'd100, 32'hFFFF_FFF9);
    wait_rdy(c);
    check("b2b first result", data_result, 32'hFFFF_FFF2);
    start_op(1, 32'h8000_0000, 32'h8000_0000);
    check("b2b first held", data_result, 32'hFFFF_FFF2);
    wait_rdy(c);
    check("b2b second latency", c, 33);
    check("b2b second result", data_result, 32'h0000_0000);
    check("b2b second exc", data_exception, 1);
    @(negedge clock);

    // Reset in the middle of RUN aborts with no completion strobe.
    start_op(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (14) @(negedge clock);
    #2 reset = 1;
    #1;
    check("abort busy", busy, 0);
    check("abort rdy", data_resultRDY, 0);
    check("abort result", data_result, 32'd0);
    check("abort exc", data_exception, 0);
    @(negedge clock);
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY) pulses++;
      @(negedge clock);
    end
    check("abort no rdy", pulses, 0);
    run_op("mul 3x3", 1, 32'd3, 32'd3, 32'd9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
- REQ-001: The block SHALL have no parameters; all datapaths are fixed at 32 bits.
- REQ-002: clock  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: ctrl_MULT  input  1  one-cycle start pulse for signed multiply; driven from the execute stage as it consumes the D/X latch.
- REQ-005: ctrl_DIV  input  1  one-cycle start pulse for signed divide.
- REQ-006: data_operandA  input  32  dividend or multiplicand (two's complement); the D/X latch a value.
- REQ-007: data_operandB  input  32  divisor or multiplier (two's complement); the D/X latch b value.
- REQ-008: data_result  output  32  quotient or low 32 bits of the product.
- REQ-009: data_exception  output  1  overflow or divide-by-zero flag for the current result.
- REQ-010: data_resultRDY  output  1  one-cycle completion strobe.
- REQ-011: busy  output  1  operation in progress; the pipeline SHALL use it to stall the F/D and D/X latches.

Function
- REQ-012: The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- REQ-013: In IDLE or DONE, a rising edge with ctrl_MULT or ctrl_DIV high SHALL capture both operands and the op type, clear the 5-bit iteration counter, and enter RUN.
- REQ-014: If ctrl_MULT and ctrl_DIV are both high on the same edge, multiply SHALL take priority.
- REQ-015: Start pulses during RUN SHALL be ignored; operands then are not captured and in-flight state is not disturbed.
- REQ-016: RUN SHALL perform one iteration per cycle for 32 cycles (counter 0..31): radix-2 shift-add for multiply, restoring shift-subtract on magnitudes for divide.
- REQ-017: After the iteration with counter==31, the FSM SHALL enter DONE.
- REQ-018: For a start sampled on edge N, data_resultRDY SHALL be high only in the cycle following edge N+32.
- REQ-019: busy SHALL be high in every RUN cycle and low in IDLE and DONE.
- REQ-020: data_result and data_exception SHALL update only on entry to DONE and SHALL hold until the next DONE entry or reset.
- REQ-021: DONE SHALL return to IDLE after one cycle unless a new start is accepted on that edge, which enters RUN back-to-back.
- REQ-022: Multiply: data_result = low 32 bits of the signed 64-bit product.
- REQ-023: Multiply: data_exception = 1 iff the 64-bit product's upper 33 bits are not all equal.
- REQ-024: Divide: the quotient SHALL truncate toward zero; the quotient sign is signA XOR signB; the remainder is not output.
- REQ-025: Divide by zero: data_result = 0x00000000, data_exception = 1, with the same 32-cycle latency.
- REQ-026: Divide 0x80000000 by 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
- REQ-027: All other divides SHALL set data_exception = 0.
- REQ-028: Magnitude of 0x80000000 SHALL be handled as the unsigned value 2^31, using a 33-bit internal width where needed.

Reset
- REQ-029: Asserting reset SHALL immediately force state IDLE, counter 0, all internal registers 0, data_result 0, data_exception 0, data_resultRDY 0 and busy 0.
- REQ-030: Reset asserted mid-RUN SHALL abort the operation with no data_resultRDY pulse; the first start after deassertion SHALL behave as from power-up.

Verification
- REQ-031: MULT 7 x 6 -> busy high 32 cycles; data_resultRDY pulses in the 33rd cycle after start; data_result 42, data_exception 0.
- REQ-032: MULT 0x00010000 x 0x00010000 -> data_result 0x00000000, data_exception 1; MULT 0xFFFFFFFF x 0x00000005 -> 0xFFFFFFFB, data_exception 0.
- REQ-033: DIV -7 / 2 -> 0xFFFFFFFD, data_exception 0; DIV 5 / 0 -> 0, data_exception 1; DIV 0x80000000 / -1 -> 0x80000000, data_exception 1.
- REQ-034: ctrl_DIV pulsed at RUN cycle 10 of a MULT -> ignored; the MULT result is unchanged; exactly one data_resultRDY pulse.
- REQ-035: New start in the DONE cycle -> the second op completes 32 cycles later with correct result; the first result holds until then.
- REQ-036: reset asserted at RUN cycle 15 -> all outputs 0 immediately; no data_resultRDY; a subsequent MULT 3 x 3 returns 9.
